// File: rtl/uart_tx_engine.sv
// Purpose: parametrised UART transmit engine (TX FIFO, baud-tick divider, framing FSM).
// Latency: write accepted at edge N into an empty FIFO while idle -> pop at N+1 -> start bit on tx_o from N+2.
// Backpressure: ready_o = FIFO not full (decoded from the registered level); writes while full are ignored.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   divisor_i           clock cycles per baud tick (0 behaves as 1)
//   word_len_i          data bits per frame, clamped to 5..MaxDataBits
//   par_mode_i          0 none, 1 odd, 2 even, 3 mark, 4 space, 5-7 none
//   stop2_i             two stop bits (1.5 for 5-bit words)
//   break_i             hold tx_o low while set; FSM keeps running underneath
//   fifo_clr_i          flush the FIFO at the next edge (beats a simultaneous write)
//   data_i/valid_i      write port, handshaked against ready_o
//   tx_o                registered serial line
//   fifo_level_o        FIFO occupancy
//   thr_empty_o         FIFO empty
//   tx_empty_o          FIFO empty and framer idle
module uart_tx_engine #(
  parameter int FifoDepth   = 16,
  parameter int DivWidth    = 16,
  parameter int MaxDataBits = 9,
  parameter int Oversample  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DivWidth-1:0]          divisor_i,
  input  logic [3:0]                   word_len_i,
  input  logic [2:0]                   par_mode_i,
  input  logic                         stop2_i,
  input  logic                         break_i,
  input  logic                         fifo_clr_i,
  input  logic [MaxDataBits-1:0]       data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         tx_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o,
  output logic                         thr_empty_o,
  output logic                         tx_empty_o
);

  localparam int PtrW  = $clog2(FifoDepth);
  localparam int LvlW  = PtrW + 1;
  // Tick counter must reach 2*Oversample-1 for two stop bits.
  localparam int TickW = $clog2(2 * Oversample) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [MaxDataBits-1:0] mem [FifoDepth];
  logic [PtrW-1:0]        wr_ptr;
  logic [PtrW-1:0]        rd_ptr;
  logic [LvlW-1:0]        level;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign full  = (level == LvlW'(FifoDepth));
  assign empty = (level == '0);
  // Flush wins over a write in the same cycle: the write is simply not taken.
  assign push  = valid_i && !full && !fifo_clr_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (fifo_clr_i) begin
      // A pop in this cycle still loads the shifter from mem[rd_ptr];
      // only the queued words are discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      level <= level + LvlW'(push) - LvlW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Config decode from the live inputs; sampled only when a word is popped.
  // ---------------------------------------------------------------------------
  logic [3:0]             wl_in;
  logic [DivWidth-1:0]    div_in;
  logic [MaxDataBits-1:0] head_dat;
  logic [MaxDataBits-1:0] mask_in;
  logic [MaxDataBits-1:0] masked_dat;
  logic                   par_en_in;
  logic                   par_bit_in;
  logic [TickW-1:0]       stop_ticks_in;

  assign head_dat   = mem[rd_ptr];
  assign div_in     = (divisor_i == '0) ? DivWidth'(1) : divisor_i;
  // For wl_in == MaxDataBits the shift overflows to zero and the
  // subtraction wraps to all ones, which is the wanted full mask.
  assign mask_in    = (MaxDataBits'(1) << wl_in) - MaxDataBits'(1);
  assign masked_dat = head_dat & mask_in;

  always_comb begin
    wl_in = word_len_i;
    if (word_len_i < 4'd5) begin
      wl_in = 4'd5;
    end else if (word_len_i > 4'(MaxDataBits)) begin
      wl_in = 4'(MaxDataBits);
    end
  end

  always_comb begin
    par_en_in  = 1'b0;
    par_bit_in = 1'b0;
    case (par_mode_i)
      3'd1: begin par_en_in = 1'b1; par_bit_in = ~^masked_dat; end
      3'd2: begin par_en_in = 1'b1; par_bit_in =  ^masked_dat; end
      3'd3: begin par_en_in = 1'b1; par_bit_in = 1'b1;         end
      3'd4: begin par_en_in = 1'b1; par_bit_in = 1'b0;         end
      default: begin par_en_in = 1'b0; par_bit_in = 1'b0;      end
    endcase
  end

  always_comb begin
    stop_ticks_in = TickW'(Oversample);
    if (stop2_i) begin
      stop_ticks_in = (wl_in == 4'd5) ? TickW'(3 * Oversample / 2)
                                      : TickW'(2 * Oversample);
    end
  end

  // ---------------------------------------------------------------------------
  // Latched frame context, baud divider and bit counters
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  state_t                 state_d;
  logic [MaxDataBits-1:0] shreg_q;
  logic [DivWidth-1:0]    div_q;
  logic [3:0]             wl_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic [TickW-1:0]       stop_ticks_q;
  logic [DivWidth-1:0]    div_cnt_q;
  logic [TickW-1:0]       tick_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [TickW-1:0]       bit_ticks;
  logic                   tick;
  logic                   bit_done;
  logic                   line;
  logic                   tx_q;

  assign tick      = (div_cnt_q == div_q - DivWidth'(1));
  assign bit_ticks = (state_q == STOP) ? stop_ticks_q : TickW'(Oversample);
  assign bit_done  = tick && (tick_cnt_q == bit_ticks - TickW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q      <= '0;
      div_q        <= DivWidth'(1);
      wl_q         <= 4'd5;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop_ticks_q <= TickW'(Oversample);
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
    end else if (pop) begin
      // Frame start: latch config and restart timing so the start bit is whole.
      shreg_q      <= head_dat;
      div_q        <= div_in;
      wl_q         <= wl_in;
      par_en_q     <= par_en_in;
      par_bit_q    <= par_bit_in;
      stop_ticks_q <= stop_ticks_in;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
    end else if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_q <= '0;
        if (bit_done) begin
          tick_cnt_q <= '0;
          if (state_q == DATA) begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end else begin
          tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
      end else begin
        div_cnt_q <= div_cnt_q + DivWidth'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    line    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        line = shreg_q[0];
        if (bit_done && (bit_cnt_q == wl_q - 4'd1)) begin
          state_d = par_en_q ? PAR : STOP;
        end
      end
      PAR: begin
        line = par_bit_q;
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        line = 1'b1;
        if (bit_done) begin
          // Back-to-back: next start bit follows the stop bit with no gap.
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line register follows the FSM by one cycle; break only masks the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= break_i ? 1'b0 : line;
    end
  end

  assign tx_o         = tx_q;
  assign ready_o      = !full;
  assign fifo_level_o = level;
  assign thr_empty_o  = empty;
  assign tx_empty_o   = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Purpose: self-checking bench for uart_tx_engine against a per-cycle line model.
// Latency: expects tx_o low two edges after a write into an idle engine.
// Backpressure: checks ready_o/level when the FIFO fills.
module tb_uart_tx_engine;

  localparam int FD   = 16;
  localparam int DW   = 16;
  localparam int MAXD = 9;
  localparam int OS   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] divisor = 16'd1;
  logic [3:0]    word_len = 4'd8;
  logic [2:0]    par_mode = 3'd0;
  logic          stop2 = 1'b0;
  logic          brk = 1'b0;
  logic          fifo_clr = 1'b0;
  logic [8:0]    data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          tx;
  logic [4:0]    level;
  logic          thr_empty;
  logic          tx_empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic       exp_q[$];
  logic [8:0] pend_q[$];

  uart_tx_engine #(
    .FifoDepth(FD), .DivWidth(DW), .MaxDataBits(MAXD), .Oversample(OS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .divisor_i(divisor), .word_len_i(word_len),
    .par_mode_i(par_mode), .stop2_i(stop2), .break_i(brk), .fifo_clr_i(fifo_clr),
    .data_i(data), .valid_i(valid), .ready_o(ready), .tx_o(tx),
    .fifo_level_o(level), .thr_empty_o(thr_empty), .tx_empty_o(tx_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_bits(input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) exp_q.push_back(v);
  endtask

  // Model of one frame on the line, built from the current config inputs.
  task automatic add_frame(input logic [8:0] d);
    int wl, cpt, ones, stop_half_bits;
    wl   = (int'(word_len) < 5) ? 5 : ((int'(word_len) > MAXD) ? MAXD : int'(word_len));
    cpt  = (divisor == 0) ? 1 : int'(divisor);
    ones = 0;
    for (int i = 0; i < wl; i++) ones += int'(d[i]);
    add_bits(1'b0, OS * cpt);
    for (int i = 0; i < wl; i++) add_bits(d[i], OS * cpt);
    case (par_mode)
      3'd1: add_bits((ones % 2) == 0, OS * cpt);
      3'd2: add_bits((ones % 2) == 1, OS * cpt);
      3'd3: add_bits(1'b1, OS * cpt);
      3'd4: add_bits(1'b0, OS * cpt);
      default: ;
    endcase
    stop_half_bits = stop2 ? ((wl == 5) ? 3 : 4) : 2;
    add_bits(1'b1, stop_half_bits * (OS / 2) * cpt);
  endtask

  task automatic rand_cfg();
    divisor  = DW'($urandom_range(0, 2));
    word_len = 4'($urandom_range(3, 11));
    par_mode = 3'($urandom_range(0, 7));
    stop2    = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after an edge; the accepting edge is the next one.
  task automatic push1(input logic [8:0] d);
    data  = d;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Walk exp_q one cycle per entry, starting at the edge after the first push.
  task automatic run(input int brk_at, input int brk_len, input int clr_at, input int cfg_at);
    logic e;
    logic in_brk;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      in_brk = (k >= brk_at) && (k < brk_at + brk_len);
      e = in_brk ? 1'b0 : exp_q[k];
      chk("line", tx, e);
      if (exp_q[k] == 1'b0) chk("busy_tx_empty", tx_empty, 0);
      if (k == clr_at + 1) chk("clr_level", level, 0);
      valid    = 1'b0;
      fifo_clr = 1'b0;
      if (pend_q.size() > 0) begin
        valid = 1'b1;
        data  = pend_q.pop_front();
      end
      if (k == clr_at) begin
        fifo_clr = 1'b1;
        valid    = 1'b1;
        data     = 9'h1FF;
      end
      if (k == cfg_at) rand_cfg();
      brk = (k + 1 >= brk_at) && (k + 1 < brk_at + brk_len);
    end
    valid    = 1'b0;
    fifo_clr = 1'b0;
    brk      = 1'b0;
    chk("end_tx_empty", tx_empty, 1);
    chk("end_level", level, 0);
  endtask

  task automatic set_cfg(input int div, input int wl, input int pm, input bit s2);
    divisor  = DW'(div);
    word_len = 4'(wl);
    par_mode = 3'(pm);
    stop2    = s2;
  endtask

  task automatic single(input logic [8:0] d);
    exp_q.delete();
    add_bits(1'b1, 1);
    add_frame(d);
    add_bits(1'b1, 1);
    push1(d);
  endtask

  initial begin
    int accepts;
    logic rdy_b;
    logic [8:0] w;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_thr_empty", thr_empty, 1);
    chk("rst_tx_empty", tx_empty, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8N1, divisor 1, 0xA5.
    set_cfg(1, 8, 0, 0);
    single(9'h0A5);
    run(-1, 0, -5, -5);

    // 7E2 divisor 3, then 7O2.
    set_cfg(3, 7, 2, 1);
    single(9'h041);
    run(-1, 0, -5, -5);
    set_cfg(3, 7, 1, 1);
    single(9'h041);
    run(-1, 0, -5, -5);

    // 5N2 (1.5 stop), then 5-bit mark parity.
    set_cfg(1, 5, 0, 1);
    single(9'h01F);
    run(-1, 0, -5, -5);
    set_cfg(1, 5, 3, 0);
    single(9'h000);
    run(-1, 0, -5, -5);

    // Back-to-back frames.
    set_cfg(1, 8, 2, 0);
    exp_q.delete();
    add_bits(1'b1, 1);
    add_frame(9'h03C);
    add_frame(9'h0C3);
    add_frame(9'h001);
    add_bits(1'b1, 1);
    pend_q.push_back(9'h0C3);
    pend_q.push_back(9'h001);
    push1(9'h03C);
    run(-1, 0, -5, -5);

    // Flush mid-frame with a simultaneous write: queued and new words vanish.
    set_cfg(1, 8, 0, 0);
    exp_q.delete();
    add_bits(1'b1, 1);
    add_frame(9'h096);
    add_bits(1'b1, 3);
    pend_q.push_back(9'h011);
    pend_q.push_back(9'h022);
    push1(9'h096);
    run(-1, 0, 50, -5);

    // Break for 40 cycles during data bits of an all-ones word.
    single(9'h0FF);
    run(40, 40, -5, -5);

    // FIFO fill with a very slow baud rate.
    set_cfg(16'hFFFF, 8, 0, 0);
    accepts = 0;
    valid   = 1'b1;
    data    = 9'h0AA;
    for (int c = 0; c < 4 * FD; c++) begin
      rdy_b = ready;
      @(posedge clk); #1;
      if (rdy_b) accepts++;
      if (!ready) break;
    end
    chk("fill_accepts", accepts, FD + 1);
    chk("fill_level", level, FD);
    chk("fill_ready", ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("full_hold_level", level, FD);
    valid = 1'b0;
    chk("fill_tx_start", tx, 0);
    chk("fill_thr_empty", thr_empty, 0);
    #2 rst = 1'b1;
    #1;
    chk("fill_rst_level", level, 0);
    chk("fill_rst_tx", tx, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a zero data bit.
    set_cfg(1, 8, 0, 0);
    data  = 9'h000;
    valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_level", level, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_tx_empty", tx_empty, 1);
    chk("mid_rst_ready", ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    single(9'h0B4);
    run(-1, 0, -5, -5);

    // Random configs and data, with a config change mid-frame.
    for (int r = 0; r < 12; r++) begin
      rand_cfg();
      w = 9'($urandom_range(0, 511));
      single(w);
      run(-1, 0, -5, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine: the successor to the fixed 8-bit, FIFO-less TX path. Word length (5..MaxDataBits), parity mode, stop bits, FIFO depth and divisor width are all generic. It contains a TX FIFO, a baud-tick generator and a framing FSM. It sits between the register interface (THR writes, LCR/DLL/DLM config) and the tx pad. It feeds the LSR thr_empty/tx_empty status bits.

Parameters:
FifoDepth, 16, TX FIFO entries; power of 2, >=2.
DivWidth, 16, width of baud divisor.
MaxDataBits, 9, max data bits per frame; range 8..9.
Oversample, 16, baud ticks per bit; must be even and >=4.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
divisor_i  in  DivWidth  clock cycles per baud tick; 0 treated as 1
word_len_i  in  4  data bits per frame; values <5 clamp to 5, values >MaxDataBits clamp to MaxDataBits
par_mode_i  in  3  0 none, 1 odd, 2 even, 3 mark(1), 4 space(0), 5-7 none
stop2_i  in  1  0: 1 stop bit; 1: 2 stop bits (1.5 when word length = 5)
break_i  in  1  force tx_o low
fifo_clr_i  in  1  synchronous FIFO flush
data_i  in  MaxDataBits  write data, LSB first on line; bits above word length ignored
valid_i  in  1  write request
ready_o  out  1  FIFO not full
tx_o  out  1  serial line
fifo_level_o  out  $clog2(FifoDepth)+1  FIFO occupancy
thr_empty_o  out  1  FIFO empty
tx_empty_o  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (async, rst_i=1):
  - tx_o=1, ready_o=1, fifo_level_o=0, thr_empty_o=1, tx_empty_o=1.
  - FSM goes to IDLE and the tick counters clear.
  - Reset mid-frame aborts the frame immediately; tx_o returns high in the same cycle.
- Handshake:
  - A write is accepted on a rising edge with valid_i && ready_o.
  - ready_o = !full, registered from occupancy. A pop in the same cycle does not allow a push when full.
  - Push and pop in the same cycle (not full) leave the level unchanged.
- fifo_clr_i:
  - Empties the FIFO at the next edge; it wins over a simultaneous push (data dropped).
  - The frame already in the shifter completes normally.
- Baud timing:
  - A divider counts 0..max(divisor_i,1)-1 and emits a tick on wrap.
  - A bit is Oversample ticks, so bit time = Oversample*max(divisor,1) cycles.
  - The divider and tick counter restart at frame start, so the start bit is always full length.
- Config latching: divisor, word length, parity mode and stop2 are latched when a word is popped. Mid-frame config changes affect only the next frame.
- FSM states:
  - IDLE: if FIFO non-empty, pop into the shifter, latch config, go to START.
  - START: tx_o=0 for 1 bit, then DATA.
  - DATA: shift LSB first for word-length bits, then PAR if parity enabled, else STOP.
  - PAR: one bit. Odd = ~^data, even = ^data, computed over the word-length bits only. Mark = 1, space = 0. Then STOP.
  - STOP: tx_o=1 for Oversample ticks (1 stop), 2*Oversample ticks (2 stop), or 3*Oversample/2 ticks (stop2=1 and word length 5).
  - Leaving STOP: if FIFO non-empty, pop and go straight to START (back-to-back frames, no idle gap); else IDLE.
- Latency: push accepted at edge N into an empty FIFO while IDLE → pop at edge N+1 → tx_o low from edge N+2.
- tx_o is registered.
- break_i:
  - tx_o=0 for as long as break_i is high, in any state.
  - FSM timing and FIFO continue unaffected; the frame bits underneath are lost to the line.
  - On deassertion tx_o resumes the current FSM value on the next cycle.
- Status:
  - thr_empty_o = (level==0).
  - tx_empty_o = thr_empty_o && state==IDLE.
  - Both are registered-derived with no combinational path from valid_i.

Test Plan:
- 8N1, divisor=1, push 0xA5 → tx_o low 2 cycles after acceptance; line 0,1,0,1,0,0,1,0,1,1 each 16 cycles (160-cycle frame); tx_empty_o=1 one cycle after stop ends.
- 7 data, even parity, stop2=1, divisor=3, push 0x41 → line 0, 1000001, parity 0, stop 1 for 96 cycles; each bit 48 cycles. Repeat with odd parity → parity bit 1.
- 5 data, no parity, stop2=1, divisor=1, push 0x1F → stop bit lasts 24 cycles; mark mode (par_mode=3) → parity bit 1 regardless of data.
- divisor=0xFFFF, push FifoDepth+2 words back-to-back → first word popped; ready_o low after FifoDepth+1 accepts; fifo_level_o=FifoDepth; remaining frames back-to-back with no idle between stop and start.
- Mid-frame: assert fifo_clr_i together with valid_i → level=0, pushed word dropped, current frame completes. Assert break_i for 40 cycles mid-data → tx_o=0 throughout, frame ends at the original cycle count.
- Assert rst_i mid-data-bit → tx_o=1 in the same cycle, level=0, tx_empty_o=1; after release, a new push frames correctly.
